// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60: pixel divider, h/v counters, blank, syncs.
// Latency: pos/blank/pix_tick/frame_start registered together; hsync/vsync one clk later.
// Backpressure: none; free-running from reset.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0,
    parameter int CLK_DIV   = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pos_h,
    output logic [9:0] pos_v,
    output logic       blank,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_param_check
            $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
        end
    endgenerate

    // Bounds kept 11 bits wide so a total of exactly 1024 still compares correctly.
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_ON  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_OFF = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_ON  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_OFF = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             blank_nxt;
    logic             hs_raw;
    logic             vs_raw;

    always_comb begin
        tick   = (div_cnt == DIV_LAST);
        h_wrap = ({1'b0, pos_h} == H_LAST);
        v_wrap = ({1'b0, pos_v} == V_LAST);
        h_nxt  = pos_h;
        v_nxt  = pos_v;
        if (tick) begin
            if (h_wrap) begin
                h_nxt = '0;
                v_nxt = v_wrap ? 10'd0 : pos_v + 10'd1;
            end else begin
                h_nxt = pos_h + 10'd1;
            end
        end
        blank_nxt = ({1'b0, h_nxt} >= H_VIS) || ({1'b0, v_nxt} >= V_VIS);
        // Sync windows decode the current position; the register below adds the lag.
        hs_raw = ({1'b0, pos_h} >= HS_ON) && ({1'b0, pos_h} < HS_OFF);
        vs_raw = ({1'b0, pos_v} >= VS_ON) && ({1'b0, pos_v} < VS_OFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            pos_h       <= '0;
            pos_v       <= '0;
            blank       <= 1'b0;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
            pos_h       <= h_nxt;
            pos_v       <= v_nxt;
            blank       <= blank_nxt;
            pix_tick    <= tick;
            frame_start <= tick && h_wrap && v_wrap;
            hsync       <= hs_raw ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= vs_raw ? SYNC_ACT : ~SYNC_ACT;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing at divide 1 and 4, and a
// tiny raster with active-high syncs) compared every clk against a pixel-count model.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;

    logic [9:0] h1, v1, h4, v4, hs_, vs_;
    logic       b1, hsy1, vsy1, t1, f1;
    logic       b4, hsy4, vsy4, t4, f4;
    logic       bs, hsys, vsys, ts, fs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(1)) d1 (
        .clk(clk), .reset(rst[0]), .pos_h(h1), .pos_v(v1), .blank(b1),
        .hsync(hsy1), .vsync(vsy1), .pix_tick(t1), .frame_start(f1));

    vga_timing_gen #(.CLK_DIV(4)) d4 (
        .clk(clk), .reset(rst[1]), .pos_h(h4), .pos_v(v4), .blank(b4),
        .hsync(hsy4), .vsync(vsy4), .pix_tick(t4), .frame_start(f4));

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1), .CLK_DIV(3)
    ) ds (
        .clk(clk), .reset(rst[2]), .pos_h(hs_), .pos_v(vs_), .blank(bs),
        .hsync(hsys), .vsync(vsys), .pix_tick(ts), .frame_start(fs));

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Output after c clks since reset: the c/div-th pixel of a row-major raster scan.
    function automatic logic [24:0] model(input int hv, hf, hs, hb, vv, vf, vs, vb,
                                          input int pol, div, input longint c);
        longint htot, vtot, frame, p, p1, h, v, hp, vp;
        logic blank, tick, fst, hact, vact, hsy, vsy;
        htot  = hv + hf + hs + hb;
        vtot  = vv + vf + vs + vb;
        frame = htot * vtot;
        p     = (c / div) % frame;
        h     = p % htot;
        v     = p / htot;
        blank = (h >= hv) || (v >= vv);
        tick  = (c > 0) && ((c % div) == 0);
        fst   = tick && (p == 0);
        hact  = 1'b0;
        vact  = 1'b0;
        if (c > 0) begin
            p1   = ((c - 1) / div) % frame;
            hp   = p1 % htot;
            vp   = p1 / htot;
            hact = (hp >= hv + hf) && (hp < hv + hf + hs);
            vact = (vp >= vv + vf) && (vp < vv + vf + vs);
        end
        hsy = hact ? pol[0] : ~pol[0];
        vsy = vact ? pol[0] : ~pol[0];
        return {10'(h), 10'(v), blank, hsy, vsy, tick, fst};
    endfunction

    task automatic check_run(input string name, inout int run, inout bit clean,
                             input bit active, input int want);
        if (active) begin
            run++;
        end else begin
            if (run > 0 && clean) chk(name, run, want);
            run   = 0;
            clean = 1'b1;
        end
    endtask

    longint cnt [3];
    bit     seen[3] = '{0, 0, 0};
    int  r_hs1 = 0, r_hs4 = 0, r_hss = 0, r_vss = 0, r_b1 = 0;
    bit  c_hs1 = 1, c_hs4 = 1, c_hss = 1, c_vss = 1, c_b1 = 1;
    bit  prev_hsy1 = 1'b1;
    logic [9:0] prev_h1 = '0;
    longint cyc = 0, last_fs = 0;
    bit     have_fs = 1'b0;

    // Compare process: advance the model on each edge, then check #1 later.
    always begin
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                cnt[k]  = 0;
                seen[k] = 1'b1;
            end else begin
                cnt[k]++;
            end
        end
        if (rst[0]) begin c_hs1 = 0; c_b1 = 0; end
        if (rst[1]) c_hs4 = 0;
        if (rst[2]) begin c_hss = 0; c_vss = 0; have_fs = 0; end
        #1;
        if (seen[0])
            chk("d1_outputs", {h1, v1, b1, hsy1, vsy1, t1, f1},
                model(640, 16, 96, 48, 480, 10, 2, 33, 0, 1, cnt[0]));
        if (seen[1])
            chk("d4_outputs", {h4, v4, b4, hsy4, vsy4, t4, f4},
                model(640, 16, 96, 48, 480, 10, 2, 33, 0, 4, cnt[1]));
        if (seen[2])
            chk("ds_outputs", {hs_, vs_, bs, hsys, vsys, ts, fs},
                model(8, 2, 3, 2, 4, 1, 2, 1, 1, 3, cnt[2]));
        if (seen[0]) begin
            check_run("d1_hsync_low_len", r_hs1, c_hs1, !hsy1, 96);
            check_run("d1_blank_len", r_b1, c_b1, b1, 160);
            if (prev_hsy1 && !hsy1) chk("d1_hsync_fall_after_656", prev_h1, 656);
            prev_hsy1 = hsy1;
            prev_h1   = h1;
        end
        if (seen[1]) check_run("d4_hsync_low_len", r_hs4, c_hs4, !hsy4, 384);
        if (seen[2]) begin
            check_run("ds_hsync_high_len", r_hss, c_hss, hsys, 9);
            check_run("ds_vsync_high_len", r_vss, c_vss, vsys, 90);
            if (fs) begin
                if (have_fs) chk("ds_frame_period", cyc - last_fs, 360);
                have_fs = 1'b1;
                last_fs = cyc;
            end
        end
    end

    int rst_left[3] = '{0, 0, 0};
    bit found;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_d1_pos", {h1, v1}, 0);
        chk("rst_d1_flags", {b1, hsy1, vsy1, t1, f1}, 5'b01100);
        chk("rst_ds_syncs_inactive", {hsys, vsys}, 2'b00);
        rst = 3'b000;
        @(negedge clk);
        chk("d1_first_tick", {h1, t1}, {10'd1, 1'b1});
        chk("d4_no_tick_yet", {h4, t4}, {10'd0, 1'b0});
        repeat (3) @(negedge clk);
        chk("d4_tick_after_4", {h4, t4}, {10'd1, 1'b1});

        // Undisturbed run covering several full lines on every instance.
        repeat (1700) @(negedge clk);

        // Reset d1 for one clk mid-line and confirm it restarts cleanly.
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if (h1 == 10'd300 && v1 == 10'd2) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) chk("wait_d1_pos_300_2", 0, 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("midline_rst_pos", {h1, v1}, 0);
        chk("midline_rst_flags", {b1, hsy1, vsy1, t1, f1}, 5'b01100);
        @(negedge clk);
        chk("midline_rst_resume", {h1, v1, t1}, {10'd1, 10'd0, 1'b1});

        // Random reset pulses of 1..3 clks on each instance.
        for (int n = 0; n < 20000; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (rst_left[k] > 0) begin
                    rst[k] = 1'b1;
                    rst_left[k]--;
                end else begin
                    rst[k] = 1'b0;
                    if ($urandom_range(0, (k == 0) ? 5000 : 1500) == 0)
                        rst_left[k] = $urandom_range(1, 3);
                end
            end
            @(negedge clk);
        end
        rst = 3'b000;
        repeat (800) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
